data_bus_arbiter: RTL and testbench
===================================

// Module: data_bus_arbiter
// PURPOSE
//  Shares the data-memory/UART bus between two masters: M0 = processor data port, M1 = UART loader/DMA master.
//  Round-robin arbitration; one transaction in flight at a time.
//  Decodes the target (data memory / UART0 / UART1), issues a single-cycle strobe and waits the target latency.
//  Returns a one-cycle ready pulse with registered read data to the granted master.
// PARAMETERS
//  DATA_WIDTH   32  width of address and data buses
//  MEM_LATENCY  1   cycles (>=1) from data-memory strobe to valid read data
//  UART_LATENCY 2   cycles (>=1) from UART strobe to valid read data
// PORTS
//  clock            in   1   system clock, rising edge
//  reset            in   1   asynchronous, active-low reset
//  m0_read/m0_write in   1   M0 request; held until m0_ready
//  m0_address       in   32  M0 byte address
//  m0_write_data    in   32  M0 write data
//  m0_read_data     out  32  M0 read data, valid while m0_ready=1, held afterwards
//  m0_ready         out  1   one-cycle completion pulse for M0
//  m1_*             --   --  identical set for M1
//  bus_address      out  32  latched address of the granted transaction
//  bus_write_data   out  32  latched write data
//  mem_read/mem_write     out 1 strobe to data memory
//  uart0_read/uart0_write out 1 strobe to UART0
//  uart1_read/uart1_write out 1 strobe to UART1
//  mem_read_data, uart0_read_data, uart1_read_data  in 32  target read data
//  grant            out  2   one-hot current owner {M1,M0}; 00 when idle
//  busy             out  1   1 in any state other than IDLE
// BEHAVIOUR
//  Decode on the latched address:
//   - addr[8]=0 -> MEM
//   - addr[8]=1, addr[9]=0 -> UART0
//   - addr[8]=1, addr[9]=1 -> UART1
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//   - IDLE: a master requests when read|write=1.
//   - IDLE, one requester: grant it.
//   - IDLE, both requesting: grant the master not granted last (last_grant register).
//   - On grant, latch address, write data, op and target; go to ACCESS; set lat_cnt = target latency.
//   - ACCESS: target strobe high in the FIRST ACCESS cycle only (one UART FIFO push/pop per transaction).
//     lat_cnt decrements each cycle. On the cycle lat_cnt==1, sample the selected target read data (reads only)
//     into the master's read_data register, then go to DONE.
//   - DONE: the owner's ready=1 for exactly one cycle, then IDLE. Grant stays asserted through ACCESS and DONE.
//  Latency: request at cycle 0 (IDLE) -> strobe at cycle 1 -> ready at cycle 1+LATENCY
//   (MEM: cycle 2; UART: cycle 3). Minimum spacing between back-to-back grants is LATENCY+2 cycles.
//  Requests are sampled only in IDLE; requests changing during ACCESS/DONE are ignored.
//  A master must drop its request in its ready cycle, or the request is re-arbitrated as a new transaction.
//  read and write both high: treated as a write; the read is ignored and read_data is unchanged.
//  Writes: read_data unchanged; ready still pulses.
//  Strobes are mutually exclusive; all strobes are 0 outside the first ACCESS cycle.
//  Reset (async, any state): state=IDLE, grant=00, busy=0, all strobes=0, m*_ready=0, m*_read_data=0,
//   bus_address=0, bus_write_data=0, last_grant=M1 (so M0 wins the first tie).
//   Reset mid-transaction aborts it with no ready pulse.
// TESTING
//  1. M0 read 0x00000010, MEM returns 0xDEADBEEF -> mem_read high cycle 1 only; m0_ready cycle 2; m0_read_data=0xDEADBEEF.
//  2. M1 write 0x00000104 data 0x41 -> uart0_write one cycle; bus_write_data=0x41; m1_ready at cycle 3; m1_read_data unchanged.
//  3. M0 and M1 request together after reset -> M0 served first, then M1; with both held continuously, grants alternate M0,M1,M0.
//  4. M1 read 0x00000300, UART1 returns 0x5A -> uart1_read single pulse; m1_ready at cycle 3 with 0x5A; uart0/mem strobes stay 0.
//  5. reset low during ACCESS of an M0 UART read -> outputs at reset values immediately; no m0_ready; next request served normally.
//  6. M0 read+write both high at 0x00000020 -> mem_write only, mem_read stays 0; m0_ready pulses; m0_read_data keeps its old value.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter sharing the data-memory / UART bus between the processor data port (M0)
// and the UART loader (M1); one transaction in flight, strobe once, wait target latency, pulse ready.
module data_bus_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int UART_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_WIDTH-1:0] m0_address,
    input  logic [DATA_WIDTH-1:0] m0_write_data,
    output logic [DATA_WIDTH-1:0] m0_read_data,
    output logic                  m0_ready,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_WIDTH-1:0] m1_address,
    input  logic [DATA_WIDTH-1:0] m1_write_data,
    output logic [DATA_WIDTH-1:0] m1_read_data,
    output logic                  m1_ready,
    output logic [DATA_WIDTH-1:0] bus_address,
    output logic [DATA_WIDTH-1:0] bus_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  uart0_read,
    output logic                  uart0_write,
    output logic                  uart1_read,
    output logic                  uart1_write,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic [DATA_WIDTH-1:0] uart0_read_data,
    input  logic [DATA_WIDTH-1:0] uart1_read_data,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic [1:0] {TGT_MEM = 2'd0, TGT_UART0 = 2'd1, TGT_UART1 = 2'd2} tgt_t;

    state_t                state_q, state_d;
    tgt_t                  tgt_q, tgt_d;
    logic                  owner_q, owner_d;       // 0 = M0, 1 = M1
    logic                  last_q, last_d;
    logic                  write_op_q, write_op_d;
    logic                  first_q, first_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic                  req0, req1, pick1, sel_write;
    logic [DATA_WIDTH-1:0] sel_addr, sel_rdata;
    tgt_t                  sel_tgt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tgt_q      <= TGT_MEM;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            write_op_q <= 1'b0;
            first_q    <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            write_op_q <= write_op_d;
            first_q    <= first_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        owner_d    = owner_q;
        last_d     = last_q;
        write_op_d = write_op_q;
        first_d    = 1'b0;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;

        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        // On a tie the master that did not win last time takes the bus.
        pick1     = req1 && (!req0 || !last_q);
        sel_addr  = pick1 ? m1_address : m0_address;
        sel_write = pick1 ? m1_write : m0_write;
        if (!sel_addr[8])      sel_tgt = TGT_MEM;
        else if (!sel_addr[9]) sel_tgt = TGT_UART0;
        else                   sel_tgt = TGT_UART1;

        case (tgt_q)
            TGT_UART0: sel_rdata = uart0_read_data;
            TGT_UART1: sel_rdata = uart1_read_data;
            default:   sel_rdata = mem_read_data;
        endcase

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d    = ACCESS;
                    owner_d    = pick1;
                    last_d     = pick1;
                    addr_d     = sel_addr;
                    wdata_d    = pick1 ? m1_write_data : m0_write_data;
                    write_op_d = sel_write;
                    tgt_d      = sel_tgt;
                    first_d    = 1'b1;
                    cnt_d      = (sel_tgt == TGT_MEM) ? CNT_W'(MEM_LATENCY) : CNT_W'(UART_LATENCY);
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    if (!write_op_q) begin
                        if (owner_q) rdata1_d = sel_rdata;
                        else         rdata0_d = sel_rdata;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The strobe is confined to the first ACCESS cycle so a UART FIFO sees one push/pop.
    logic strobe;
    assign strobe = (state_q == ACCESS) && first_q;

    assign mem_read    = strobe && (tgt_q == TGT_MEM)   && !write_op_q;
    assign mem_write   = strobe && (tgt_q == TGT_MEM)   &&  write_op_q;
    assign uart0_read  = strobe && (tgt_q == TGT_UART0) && !write_op_q;
    assign uart0_write = strobe && (tgt_q == TGT_UART0) &&  write_op_q;
    assign uart1_read  = strobe && (tgt_q == TGT_UART1) && !write_op_q;
    assign uart1_write = strobe && (tgt_q == TGT_UART1) &&  write_op_q;

    assign busy           = (state_q != IDLE);
    assign grant          = busy ? {owner_q, !owner_q} : 2'b00;
    assign m0_ready       = (state_q == DONE) && !owner_q;
    assign m1_ready       = (state_q == DONE) &&  owner_q;
    assign m0_read_data   = rdata0_q;
    assign m1_read_data   = rdata1_q;
    assign bus_address    = addr_q;
    assign bus_write_data = wdata_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: transaction table plus hand-written tie, reset-abort sequences.
module tb_data_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
    logic [31:0] m0_address = 0, m0_write_data = 0, m1_address = 0, m1_write_data = 0;
    logic [31:0] m0_read_data, m1_read_data, bus_address, bus_write_data;
    logic        m0_ready, m1_ready;
    logic        mem_read, mem_write, uart0_read, uart0_write, uart1_read, uart1_write;
    logic [31:0] mem_read_data = 0, uart0_read_data = 0, uart1_read_data = 0;
    logic [1:0]  grant, dbg_state;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    data_bus_arbiter dut (
        .clock(clock), .reset(reset),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_write_data(m0_write_data), .m0_read_data(m0_read_data), .m0_ready(m0_ready),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_write_data(m1_write_data), .m1_read_data(m1_read_data), .m1_ready(m1_ready),
        .bus_address(bus_address), .bus_write_data(bus_write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .uart0_read(uart0_read), .uart0_write(uart0_write),
        .uart1_read(uart1_read), .uart1_write(uart1_write),
        .mem_read_data(mem_read_data), .uart0_read_data(uart0_read_data),
        .uart1_read_data(uart1_read_data),
        .grant(grant), .busy(busy), .dbg_state(dbg_state)
    );

    logic [5:0] strb;
    assign strb = {uart1_write, uart1_read, uart0_write, uart0_read, mem_write, mem_read};

    typedef struct {
        logic        m0_rd, m0_wr;
        logic [31:0] m0_addr, m0_wd;
        logic        m1_rd, m1_wr;
        logic [31:0] m1_addr, m1_wd;
        logic [31:0] mem_rd, u0_rd, u1_rd;
        logic        exp_owner;
        logic [5:0]  exp_strb;
        int          exp_rdy_cyc;
        logic [31:0] exp_rdata, exp_baddr, exp_bwd;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drop_reqs();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " grant"}, {30'd0, grant}, 32'd0);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " strobes"}, {26'd0, strb}, 32'd0);
        chk({tag, " ready"}, {30'd0, m1_ready, m0_ready}, 32'd0);
        chk({tag, " m0_rdata"}, m0_read_data, 32'd0);
        chk({tag, " m1_rdata"}, m1_read_data, 32'd0);
        chk({tag, " bus_addr"}, bus_address, 32'd0);
        chk({tag, " bus_wdata"}, bus_write_data, 32'd0);
        chk({tag, " state"}, {30'd0, dbg_state}, 32'd0);
    endtask

    // Called at posedge+1 of an IDLE cycle; drives the vector as cycle 0.
    task automatic run_txn(input vec_t v, input string tag);
        int  cyc;
        bit  done;
        logic own_rdy, oth_rdy;
        logic [31:0] own_rdata;
        m0_read = v.m0_rd; m0_write = v.m0_wr; m0_address = v.m0_addr; m0_write_data = v.m0_wd;
        m1_read = v.m1_rd; m1_write = v.m1_wr; m1_address = v.m1_addr; m1_write_data = v.m1_wd;
        mem_read_data = v.mem_rd; uart0_read_data = v.u0_rd; uart1_read_data = v.u1_rd;
        #1;
        chk({tag, " idle busy"}, {31'd0, busy}, 32'd0);
        cyc = 0;
        done = 0;
        while (!done && cyc < 10) begin
            @(posedge clock); #1;
            cyc++;
            own_rdy   = v.exp_owner ? m1_ready : m0_ready;
            oth_rdy   = v.exp_owner ? m0_ready : m1_ready;
            own_rdata = v.exp_owner ? m1_read_data : m0_read_data;
            chk($sformatf("%s strobe c%0d", tag, cyc), {26'd0, strb},
                (cyc == 1) ? {26'd0, v.exp_strb} : 32'd0);
            chk($sformatf("%s grant c%0d", tag, cyc), {30'd0, grant},
                v.exp_owner ? 32'd2 : 32'd1);
            chk($sformatf("%s other_ready c%0d", tag, cyc), {31'd0, oth_rdy}, 32'd0);
            if (own_rdy) begin
                done = 1;
                chk({tag, " ready_cycle"}, cyc, v.exp_rdy_cyc);
                chk({tag, " rdata"}, own_rdata, v.exp_rdata);
                chk({tag, " bus_addr"}, bus_address, v.exp_baddr);
                chk({tag, " bus_wdata"}, bus_write_data, v.exp_bwd);
                chk({tag, " state_done"}, {30'd0, dbg_state}, 32'd2);
                drop_reqs();
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s ready_timeout actual=none expected=cycle %0d", tag, v.exp_rdy_cyc);
            drop_reqs();
        end
        @(posedge clock); #1;
        chk({tag, " ready_pulse_len"}, {30'd0, m1_ready, m0_ready}, 32'd0);
        chk({tag, " back_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // m0_rd m0_wr m0_addr m0_wd | m1_rd m1_wr m1_addr m1_wd | mem u0 u1 | owner strb rdy rdata baddr bwd
        vecs[0] = '{1, 0, 32'h10,  32'h0,    0, 0, 32'h0,   32'h0,  32'hDEADBEEF, 32'h1, 32'h2,
                    0, 6'b000001, 2, 32'hDEADBEEF, 32'h10, 32'h0};
        vecs[1] = '{0, 0, 32'h0,   32'h0,    0, 1, 32'h104, 32'h41, 32'h3, 32'h4, 32'h5,
                    1, 6'b001000, 3, 32'h0, 32'h104, 32'h41};
        vecs[2] = '{0, 0, 32'h0,   32'h0,    1, 0, 32'h300, 32'h0,  32'h6, 32'h7, 32'h5A,
                    1, 6'b010000, 3, 32'h5A, 32'h300, 32'h0};
        vecs[3] = '{1, 1, 32'h20,  32'h1234, 0, 0, 32'h0,   32'h0,  32'h8, 32'h9, 32'hA,
                    0, 6'b000010, 2, 32'hDEADBEEF, 32'h20, 32'h1234};
        vecs[4] = '{0, 1, 32'h3FC, 32'hA5A5, 0, 0, 32'h0,   32'h0,  32'hB, 32'hC, 32'hD,
                    0, 6'b100000, 3, 32'hDEADBEEF, 32'h3FC, 32'hA5A5};
        vecs[5] = '{0, 0, 32'h0,   32'h0,    1, 0, 32'h200, 32'h0,  32'hCAFEF00D, 32'hE, 32'hF,
                    1, 6'b000001, 2, 32'hCAFEF00D, 32'h200, 32'h0};
        vecs[6] = '{1, 0, 32'h100, 32'h0,    0, 0, 32'h0,   32'h0,  32'h10, 32'h77, 32'h11,
                    0, 6'b000100, 3, 32'h77, 32'h100, 32'h0};
        vecs[7] = '{1, 0, 32'h10,  32'h0,    1, 0, 32'h104, 32'h0,  32'h12, 32'h66, 32'h13,
                    1, 6'b000100, 3, 32'h66, 32'h104, 32'h0};
        vecs[8] = '{0, 1, 32'h300, 32'hBEEF, 1, 0, 32'h10,  32'h0,  32'h14, 32'h15, 32'h16,
                    0, 6'b100000, 3, 32'h77, 32'h300, 32'hBEEF};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk_reset_vals("reset");
        reset = 1'b1;
        @(posedge clock); #1;

        // Tie after reset with both requests held: grants M0, M1, M0 spaced MEM_LATENCY+2 apart
        begin
            logic [1:0] prev_g;
            logic [1:0] g_val[3];
            int         g_cyc[3];
            int         n;
            m0_read = 1; m0_address = 32'h10;
            m1_read = 1; m1_address = 32'h20;
            mem_read_data = 32'h11111111;
            prev_g = 2'b00;
            n = 0;
            for (int c = 1; c <= 12 && n < 3; c++) begin
                @(posedge clock); #1;
                if (grant != 2'b00 && prev_g == 2'b00) begin
                    g_val[n] = grant;
                    g_cyc[n] = c;
                    n++;
                end
                prev_g = grant;
            end
            drop_reqs();
            chk("tie grant_count", n, 3);
            if (n == 3) begin
                chk("tie grant0", {30'd0, g_val[0]}, 32'd1);
                chk("tie grant1", {30'd0, g_val[1]}, 32'd2);
                chk("tie grant2", {30'd0, g_val[2]}, 32'd1);
                chk("tie grant1_cycle", g_cyc[1], 4);
                chk("tie grant2_cycle", g_cyc[2], 7);
            end
            repeat (4) @(posedge clock);
            #1;
            chk("tie drained", {31'd0, busy}, 32'd0);
            chk("tie m1_rdata", m1_read_data, 32'h11111111);
        end

        // Re-enter reset so the table starts from reset read data and last_grant
        reset = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 9; i++) run_txn(vecs[i], $sformatf("v%0d", i));

        // Reset during ACCESS of an M0 UART read aborts it with no ready pulse
        begin
            vec_t post;
            m0_read = 1; m0_address = 32'h100; uart0_read_data = 32'h99;
            @(posedge clock); #1;
            chk("abort strobe_seen", {31'd0, uart0_read}, 32'd1);
            reset = 1'b0;
            #1;
            chk_reset_vals("abort");
            m0_read = 0;
            #2;
            reset = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(posedge clock); #1;
                chk($sformatf("abort no_ready c%0d", c), {30'd0, m1_ready, m0_ready}, 32'd0);
            end
            post = '{1, 0, 32'h104, 32'h0, 0, 0, 32'h0, 32'h0, 32'h1, 32'h99, 32'h2,
                     0, 6'b000100, 3, 32'h99, 32'h104, 32'h0};
            run_txn(post, "post_abort");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
